// File: rtl/afe_rd_pkg.sv
// -----------------------------------------------------------------------------
// afe_rd_pkg
// Shared definitions for the AFE -> ADS readout block:
//   - DATA_W_DEF / CH_NUM_DEF : default ADC word width and channels per frame
//   - TESTPAT_LO              : low byte of the synthetic test-pattern word
//   - rd_state_t              : readout sequencer states
// -----------------------------------------------------------------------------
package afe_rd_pkg;

   localparam int         DATA_W_DEF = 16;
   localparam int         CH_NUM_DEF = 64;
   localparam logic [7:0] TESTPAT_LO = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_EDGE,
      SETTLE,
      CONV,
      WAIT_BUSY,
      SHIFT,
      PUSH
   } rd_state_t;

endpackage

// File: rtl/ads_spi_shift.sv
// -----------------------------------------------------------------------------
// ads_spi_shift
// Serial read of one ADS conversion result, MSB first.
// Ports:
//   CLK_100M, CLK_RST : system clock, asynchronous active-high reset
//   start             : one-cycle request; CS_N drops and SCLK starts low
//   sdo               : ADC serial data, captured on every SCLK rise
//   cs_n, sclk        : ADC chip select (active-low) and serial clock
//   data              : assembled word (valid when done is high)
//   done              : high on the last cycle of the read; on the following
//                       edge SCLK returns low and CS_N is released
// -----------------------------------------------------------------------------
module ads_spi_shift #(
   parameter int DATA_W    = 16,
   parameter int SCLK_HALF = 2
) (
   input  logic              CLK_100M,
   input  logic              CLK_RST,
   input  logic              start,
   input  logic              sdo,
   output logic              cs_n,
   output logic              sclk,
   output logic [DATA_W-1:0] data,
   output logic              done
);

   localparam int HC_W = $clog2(SCLK_HALF) + 1;
   localparam int BC_W = $clog2(DATA_W + 1);

   logic            active;
   logic [HC_W-1:0] half_cnt;
   logic [BC_W-1:0] bit_cnt;

   // Last half period of the final high phase: all bits are in.
   assign done = active && sclk && (bit_cnt == BC_W'(DATA_W)) &&
                 (half_cnt == HC_W'(SCLK_HALF - 1));

   always_ff @(posedge CLK_100M or posedge CLK_RST) begin
      if (CLK_RST) begin
         active   <= 1'b0;
         cs_n     <= 1'b1;
         sclk     <= 1'b0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         data     <= '0;
      end else if (!active) begin
         if (start) begin
            active   <= 1'b1;
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
         end
      end else if (half_cnt == HC_W'(SCLK_HALF - 1)) begin
         half_cnt <= '0;
         sclk     <= ~sclk;
         if (!sclk) begin
            // SDO is captured on the same edge that raises SCLK
            data    <= {data[DATA_W-2:0], sdo};
            bit_cnt <= bit_cnt + 1'b1;
         end else if (bit_cnt == BC_W'(DATA_W)) begin
            active <= 1'b0;
            cs_n   <= 1'b1;
         end
      end else begin
         half_cnt <= half_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/afe_ads_readout.sv
// -----------------------------------------------------------------------------
// afe_ads_readout
// Sequences one ADS conversion per AFE channel and hands each sample to a
// consumer through a single-entry valid/ready holding register.
// Ports:
//   CLK_100M, CLK_RST        : system clock, asynchronous active-high reset
//   AFE_STI, AFE_CLK, AFE_STO: AFE frame start, channel shift clock, shift done
//   ADS_CONVST, ADS_BUSY     : ADC conversion start / converting
//   ADS_CS_N, ADS_SCLK, ADS_SDO : ADC serial read port
//   DOUT_DATA, DOUT_CH, DOUT_VALID, DOUT_LAST, DOUT_READY : sample stream
//   FRAME_DONE               : one-cycle end-of-frame pulse
//   OVERRUN, EDGE_ERR        : sticky errors, cleared at the next frame start
// Build option: define AFE_RD_TESTPAT_EN to replace ADC data with
//   {channel, 8'hA5}; the ADC handshake and timing are unchanged.
// -----------------------------------------------------------------------------
module afe_ads_readout
   import afe_rd_pkg::*;
#(
   parameter int CH_NUM     = CH_NUM_DEF,
   parameter int SETTLE_CYC = 20,
   parameter int CONV_CYC   = 4,
   parameter int SCLK_HALF  = 2,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic              CLK_100M,
   input  logic              CLK_RST,
   input  logic              AFE_STI,
   input  logic              AFE_CLK,
   input  logic              AFE_STO,
   output logic              ADS_CONVST,
   input  logic              ADS_BUSY,
   output logic              ADS_CS_N,
   output logic              ADS_SCLK,
   input  logic              ADS_SDO,
   output logic [DATA_W-1:0] DOUT_DATA,
   output logic [5:0]        DOUT_CH,
   output logic              DOUT_VALID,
   output logic              DOUT_LAST,
   input  logic              DOUT_READY,
   output logic              FRAME_DONE,
   output logic              OVERRUN,
   output logic              EDGE_ERR
);

   localparam int CH_W    = $clog2(CH_NUM + 1);
   localparam int CNT_MAX = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   rd_state_t         state;
   logic [CH_W-1:0]   ch_cnt;
   logic [CNT_W-1:0]  cnt;
   logic              afe_sti_p1;
   logic              afe_clk_p1;
   logic              sti_rise;
   logic              clk_rise;
   logic              spi_start;
   logic              spi_done;
   logic [DATA_W-1:0] spi_data;
   logic [DATA_W-1:0] push_word;
   logic              last_ch;

   // Stage p1: previous-cycle copies of the AFE strobes for edge detection
   always_ff @(posedge CLK_100M or posedge CLK_RST) begin
      if (CLK_RST) begin
         afe_sti_p1 <= 1'b0;
         afe_clk_p1 <= 1'b0;
      end else begin
         afe_sti_p1 <= AFE_STI;
         afe_clk_p1 <= AFE_CLK;
      end
   end

   assign sti_rise  = AFE_STI && !afe_sti_p1;
   assign clk_rise  = AFE_CLK && !afe_clk_p1;
   // Combinational start so CS_N drops on the same edge that enters SHIFT
   assign spi_start = (state == WAIT_BUSY) && !ADS_BUSY;
   assign last_ch   = (ch_cnt == CH_W'(CH_NUM - 1));

`ifdef AFE_RD_TESTPAT_EN
   assign push_word = (DATA_W'(ch_cnt) << 8) | DATA_W'(TESTPAT_LO);
`else
   assign push_word = spi_data;
`endif

   ads_spi_shift #(
      .DATA_W    (DATA_W),
      .SCLK_HALF (SCLK_HALF)
   ) u_spi (
      .CLK_100M (CLK_100M),
      .CLK_RST  (CLK_RST),
      .start    (spi_start),
      .sdo      (ADS_SDO),
      .cs_n     (ADS_CS_N),
      .sclk     (ADS_SCLK),
      .data     (spi_data),
      .done     (spi_done)
   );

   always_ff @(posedge CLK_100M or posedge CLK_RST) begin
      if (CLK_RST) begin
         state      <= IDLE;
         ch_cnt     <= '0;
         cnt        <= '0;
         ADS_CONVST <= 1'b0;
         DOUT_DATA  <= '0;
         DOUT_CH    <= '0;
         DOUT_VALID <= 1'b0;
         DOUT_LAST  <= 1'b0;
         FRAME_DONE <= 1'b0;
         OVERRUN    <= 1'b0;
         EDGE_ERR   <= 1'b0;
      end else begin
         FRAME_DONE <= 1'b0;
         // A channel edge while a conversion is in flight is flagged only
         if (clk_rise && (state != IDLE) && (state != WAIT_EDGE))
            EDGE_ERR <= 1'b1;
         if (DOUT_VALID && DOUT_READY)
            DOUT_VALID <= 1'b0;

         case (state)
            IDLE: begin
               if (sti_rise) begin
                  state    <= WAIT_EDGE;
                  ch_cnt   <= '0;
                  OVERRUN  <= 1'b0;
                  EDGE_ERR <= 1'b0;
               end
            end
            WAIT_EDGE: begin
               if (clk_rise) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end else if (AFE_STO) begin
                  state      <= IDLE;
                  FRAME_DONE <= 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                  state      <= CONV;
                  cnt        <= '0;
                  ADS_CONVST <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CONV: begin
               if (cnt == CNT_W'(CONV_CYC - 1)) begin
                  state      <= WAIT_BUSY;
                  ADS_CONVST <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_BUSY: begin
               if (!ADS_BUSY)
                  state <= SHIFT;
            end
            SHIFT: begin
               if (spi_done)
                  state <= PUSH;
            end
            PUSH: begin
               // Held sample wins over a new one the consumer cannot take
               if (DOUT_VALID && !DOUT_READY) begin
                  OVERRUN <= 1'b1;
               end else begin
                  DOUT_DATA  <= push_word;
                  DOUT_CH    <= 6'(ch_cnt);
                  DOUT_LAST  <= last_ch;
                  DOUT_VALID <= 1'b1;
               end
               ch_cnt <= ch_cnt + 1'b1;
               if (last_ch) begin
                  state      <= IDLE;
                  FRAME_DONE <= 1'b1;
               end else begin
                  state <= WAIT_EDGE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_afe_ads_readout.sv
// -----------------------------------------------------------------------------
// tb_afe_ads_readout
// Bench for afe_ads_readout: AFE stimulus, an ADS ADC model (BUSY and serial
// data), a sample-stream expectation queue and directed end-of-phase checks.
// -----------------------------------------------------------------------------
module tb_afe_ads_readout;

   localparam int CH_NUM     = 64;
   localparam int SETTLE_CYC = 20;
   localparam int CONV_CYC   = 4;
   localparam int SCLK_HALF  = 2;
   localparam int DATA_W     = 16;

   typedef struct packed {
      logic [15:0] d;
      logic [5:0]  ch;
      logic        last;
   } sample_t;

   logic        CLK_100M = 1'b0;
   logic        CLK_RST;
   logic        AFE_STI, AFE_CLK, AFE_STO;
   logic        ADS_CONVST, ADS_BUSY, ADS_CS_N, ADS_SCLK, ADS_SDO;
   logic [15:0] DOUT_DATA;
   logic [5:0]  DOUT_CH;
   logic        DOUT_VALID, DOUT_LAST, DOUT_READY;
   logic        FRAME_DONE, OVERRUN, EDGE_ERR;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   sample_t     exp_q[$];
   logic [15:0] got_data [64];
   int          last_ch   = -1;
   int          n_samples = 0, n_last = 0, n_fd = 0;
   int          cur_ch = 0, ch_idx = 0, rise_cyc = 0, cv_rise_cyc = 0;
   int          busy_cnt = 1000, bit_idx = 0, sclk_rises = 0;
   logic [15:0] sdo_word = 16'h8001, word_lat = 16'h0;
   logic        ready_arm = 1'b0;
   logic        cs_prev = 1'b1, sclk_prev = 1'b0, cv_prev = 1'b0, fd_prev = 1'b0;
   logic        vld_prev = 1'b0, rdy_prev = 1'b0, last_prev = 1'b0;
   logic [15:0] data_prev = '0;
   logic [5:0]  ch_prev = '0;
   int          b_s, b_l, b_fd;

   afe_ads_readout #(
      .CH_NUM(CH_NUM), .SETTLE_CYC(SETTLE_CYC), .CONV_CYC(CONV_CYC),
      .SCLK_HALF(SCLK_HALF), .DATA_W(DATA_W)
   ) dut (
      .CLK_100M(CLK_100M), .CLK_RST(CLK_RST),
      .AFE_STI(AFE_STI), .AFE_CLK(AFE_CLK), .AFE_STO(AFE_STO),
      .ADS_CONVST(ADS_CONVST), .ADS_BUSY(ADS_BUSY),
      .ADS_CS_N(ADS_CS_N), .ADS_SCLK(ADS_SCLK), .ADS_SDO(ADS_SDO),
      .DOUT_DATA(DOUT_DATA), .DOUT_CH(DOUT_CH), .DOUT_VALID(DOUT_VALID),
      .DOUT_LAST(DOUT_LAST), .DOUT_READY(DOUT_READY),
      .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .EDGE_ERR(EDGE_ERR)
   );

   always #5 CLK_100M = ~CLK_100M;
   always @(posedge CLK_100M) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK_100M);
      #1;
   endtask

   function automatic logic [15:0] word_for(input int ch);
      return 16'h8001 ^ (16'(ch) * 16'h0203);
   endfunction

   // ADC model, expected-sample queue and per-cycle stream checks
   task automatic mon_step();
      sample_t e;
      if (CLK_RST) begin
         exp_q.delete();
         busy_cnt = 1000;
         ADS_BUSY = 1'b0;
      end else begin
         if (ADS_CONVST && !cv_prev) begin
            busy_cnt    = 0;
            cv_rise_cyc = cyc;
            check("convst_latency", cyc - rise_cyc, SETTLE_CYC + 1);
         end else if (busy_cnt < 1000) begin
            busy_cnt++;
         end
         if (!ADS_CONVST && cv_prev)
            check("convst_width", cyc - cv_rise_cyc, CONV_CYC);
         ADS_BUSY = (busy_cnt < 10);

         if (cs_prev && !ADS_CS_N) begin
            word_lat   = sdo_word;
            bit_idx    = DATA_W - 1;
            sclk_rises = 0;
            check("sclk_low_at_cs_fall", ADS_SCLK, 0);
         end else if (!ADS_CS_N && sclk_prev && !ADS_SCLK && bit_idx > 0) begin
            bit_idx--;
         end
         if (!ADS_CS_N && !sclk_prev && ADS_SCLK) sclk_rises++;
         ADS_SDO = word_lat[bit_idx];

         if (!cs_prev && ADS_CS_N) begin
            check("sclk_rises", sclk_rises, DATA_W);
            check("sclk_low_at_cs_rise", ADS_SCLK, 0);
            if (ready_arm) DOUT_READY = 1'b1;
            e = '{d: word_lat, ch: 6'(cur_ch), last: (cur_ch == CH_NUM - 1)};
            // A sample still waiting on a stalled consumer blocks the new one
            if (!(exp_q.size() > 0 && !DOUT_READY)) exp_q.push_back(e);
         end

         if (DOUT_VALID && vld_prev && !rdy_prev)
            check("hold_stable", {DOUT_DATA, DOUT_CH, DOUT_LAST},
                  {data_prev, ch_prev, last_prev});
         if (DOUT_VALID && DOUT_READY) begin
            check("sample_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("dout_data", DOUT_DATA, e.d);
               check("dout_ch", DOUT_CH, e.ch);
               check("dout_last", DOUT_LAST, e.last);
            end
            got_data[DOUT_CH] = DOUT_DATA;
            n_samples++;
            if (DOUT_LAST) begin
               n_last++;
               last_ch = DOUT_CH;
            end
         end
         if (FRAME_DONE) begin
            n_fd++;
            check("frame_done_width", fd_prev, 0);
         end
      end
      cs_prev   = ADS_CS_N;
      sclk_prev = ADS_SCLK;
      cv_prev   = ADS_CONVST;
      fd_prev   = FRAME_DONE;
      vld_prev  = DOUT_VALID;
      rdy_prev  = DOUT_READY;
      data_prev = DOUT_DATA;
      ch_prev   = DOUT_CH;
      last_prev = DOUT_LAST;
   endtask

   task automatic check_reset(input string p);
      check({p, "_convst"}, ADS_CONVST, 0);
      check({p, "_cs_n"}, ADS_CS_N, 1);
      check({p, "_sclk"}, ADS_SCLK, 0);
      check({p, "_valid"}, DOUT_VALID, 0);
      check({p, "_last"}, DOUT_LAST, 0);
      check({p, "_data"}, DOUT_DATA, 0);
      check({p, "_ch"}, DOUT_CH, 0);
      check({p, "_frame_done"}, FRAME_DONE, 0);
      check({p, "_overrun"}, OVERRUN, 0);
      check({p, "_edge_err"}, EDGE_ERR, 0);
   endtask

   task automatic sti_pulse();
      ch_idx  = 0;
      AFE_STI = 1'b1;
      tick(3);
      AFE_STI = 1'b0;
      tick(3);
   endtask

   task automatic afe_ch(input bit legit, input bit extra);
      if (legit) begin
         cur_ch   = ch_idx;
         sdo_word = word_for(ch_idx);
         rise_cyc = cyc;
         ch_idx++;
      end
      AFE_CLK = 1'b1;
      tick(5);
      AFE_CLK = 1'b0;
      if (extra) begin
         tick(55);
         AFE_CLK = 1'b1;
         tick(5);
         AFE_CLK = 1'b0;
         tick(65);
      end else begin
         tick(125);
      end
   endtask

   task automatic mark();
      b_s  = n_samples;
      b_l  = n_last;
      b_fd = n_fd;
   endtask

   initial begin
      CLK_RST    = 1'b1;
      AFE_STI    = 1'b0;
      AFE_CLK    = 1'b0;
      AFE_STO    = 1'b0;
      ADS_BUSY   = 1'b0;
      ADS_SDO    = 1'b0;
      DOUT_READY = 1'b1;
      fork
         forever begin
            @(negedge CLK_100M);
            mon_step();
         end
      join_none

      tick(3);
      check_reset("rst");
      CLK_RST = 1'b0;
      tick(2);
      check("post_rst_cs_n", ADS_CS_N, 1);
      check("post_rst_valid", DOUT_VALID, 0);

      // Full frame, consumer always ready
      mark();
      sti_pulse();
      for (int k = 0; k < CH_NUM; k++) afe_ch(1'b1, 1'b0);
      tick(20);
      check("A_samples", n_samples - b_s, CH_NUM);
      check("A_last_count", n_last - b_l, 1);
      check("A_last_ch", last_ch, 63);
      check("A_frame_done", n_fd - b_fd, 1);
      check("A_queue_empty", exp_q.size(), 0);
      check("A_ch0_data", got_data[0], 16'h8001);
      check("A_ch1_data", got_data[1], 16'h8202);
      check("A_ch63_data", got_data[63], 16'hFEBC);

      // Stalled consumer: overrun, then a push coinciding with acceptance
      DOUT_READY = 1'b0;
      mark();
      sti_pulse();
      afe_ch(1'b1, 1'b0);
      check("B_held_valid", DOUT_VALID, 1);
      check("B_held_ch", DOUT_CH, 0);
      check("B_held_data", DOUT_DATA, 16'h8001);
      check("B_no_overrun_yet", OVERRUN, 0);
      afe_ch(1'b1, 1'b0);
      check("B_overrun", OVERRUN, 1);
      check("B_kept_ch", DOUT_CH, 0);
      check("B_kept_data", DOUT_DATA, 16'h8001);
      ready_arm = 1'b1;
      afe_ch(1'b1, 1'b0);
      ready_arm  = 1'b0;
      DOUT_READY = 1'b1;
      check("B_samples", n_samples - b_s, 2);
      check("B_ch2_data", got_data[2], 16'h8407);
      check("B_queue_empty", exp_q.size(), 0);
      AFE_STO = 1'b1;
      tick(3);
      AFE_STO = 1'b0;
      tick(3);
      check("B_frame_done", n_fd - b_fd, 1);
      check("B_overrun_sticky", OVERRUN, 1);
      check("B_no_last", n_last - b_l, 0);

      // Next frame clears OVERRUN; stray edge mid-read; early end after 10
      mark();
      sti_pulse();
      check("C_overrun_cleared", OVERRUN, 0);
      afe_ch(1'b1, 1'b1);
      check("C_edge_err", EDGE_ERR, 1);
      check("C_first_sample", n_samples - b_s, 1);
      for (int k = 1; k < 10; k++) afe_ch(1'b1, 1'b0);
      AFE_STO = 1'b1;
      tick(3);
      AFE_STO = 1'b0;
      tick(3);
      check("D_samples", n_samples - b_s, 10);
      check("D_no_last", n_last - b_l, 0);
      check("D_frame_done", n_fd - b_fd, 1);
      check("D_queue_empty", exp_q.size(), 0);
      check("D_edge_err_sticky", EDGE_ERR, 1);

      // Reset in the middle of a serial read
      mark();
      sti_pulse();
      check("E_edge_err_cleared", EDGE_ERR, 0);
      cur_ch   = 0;
      sdo_word = word_for(0);
      rise_cyc = cyc;
      AFE_CLK  = 1'b1;
      tick(5);
      AFE_CLK  = 1'b0;
      tick(55);
      check("E_in_shift_cs_n", ADS_CS_N, 0);
      #1 CLK_RST = 1'b1;
      #1 check("E_cs_n_async", ADS_CS_N, 1);
      tick(2);
      check_reset("E_rst");
      CLK_RST = 1'b0;
      tick(150);
      check("E_no_frame_done", n_fd - b_fd, 0);
      check("E_no_sample", n_samples - b_s, 0);

      // Block works normally after the abandoned frame
      mark();
      sti_pulse();
      afe_ch(1'b1, 1'b0);
      check("F_sample", n_samples - b_s, 1);
      check("F_ch", DOUT_CH, 0);
      check("F_data", DOUT_DATA, 16'h8001);
      check("F_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
